// File: rtl/cr_xp10_decomp_sdd_wf_arb_pkg.sv
// Shared types for the SDD word-fetch arbiter: lane beat payload, arbiter state, helpers.
package cr_xp10_decomp_sdd_wf_arb_pkg;

  localparam int unsigned SDD_WF_ARB_MAX_REQ = 4;
  localparam int unsigned SDD_WF_DATA_W      = 128;
  localparam int unsigned SDD_WF_NUMBITS_W   = 8;
  localparam int unsigned SDD_WF_FBYTES_W    = 28;
  localparam int unsigned SDD_WF_ERRCODE_W   = 4;

  typedef struct packed {
    logic [SDD_WF_DATA_W-1:0]    data;
    logic [SDD_WF_NUMBITS_W-1:0] numbits;
    logic                        sob;
    logic                        eob;
    logic                        eof;
    logic                        trace_bit;
    logic [SDD_WF_FBYTES_W-1:0]  frame_bytes_in;
    logic                        last_frame;
    logic [SDD_WF_ERRCODE_W-1:0] errcode;
  } sdd_wf_beat_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A beat closing a block or a frame releases the grant.
  function automatic logic beat_is_last(input sdd_wf_beat_t b);
    return b.eob | b.eof;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_sdd_wf_arb_rr_pick.sv
// Combinational round-robin pick: first valid requester scanning from i_rr_ptr upward.
module cr_xp10_decomp_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = 32'(i_rr_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!o_any && i_valid[IDX_W'(w_j)]) begin
        o_any                  = 1'b1;
        o_grant[IDX_W'(w_j)]   = 1'b1;
        o_idx                  = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_sdd_wf_arb.sv
// Block-granular round-robin arbiter muxing NUM_REQ word-fetch beat streams onto the lanes input.
// Zero latency: selection and mux are combinational; only lock/pointer/counter state is registered.
module cr_xp10_decomp_sdd_wf_arb
  import cr_xp10_decomp_sdd_wf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic         [NUM_REQ-1:0]            req_valid,
  input  sdd_wf_beat_t [NUM_REQ-1:0]            req_beat,
  output logic         [NUM_REQ-1:0]            req_ready,
  output logic                                  wf_lanes_valid,
  output sdd_wf_beat_t                          wf_lanes_beat,
  input  logic                                  lanes_wf_ready,
  output logic         [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                                  grant_locked,
  output logic                                  sob_err_stb,
  input  logic                                  stall_cnt_clr,
  output logic         [STALL_CNT_W-1:0]        lanes_stall_cnt,
  output logic         [NUM_REQ-1:0][STALL_CNT_W-1:0] starve_cnt
);

  localparam int unsigned          IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  arb_state_e                          r_state, w_state_nxt;
  logic [IDX_W-1:0]                    r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]                    r_lock_id, w_lock_id_nxt;
  logic                                r_pend, w_pend_nxt;
  logic                                r_sob_err, w_sob_err_nxt;
  logic [NUM_REQ-1:0]                  w_pick_onehot;
  logic [IDX_W-1:0]                    w_pick_idx;
  logic                                w_pick_any;
  logic                                w_hold;
  logic [IDX_W-1:0]                    w_sel;
  logic                                w_valid;
  logic                                w_xfer;
  logic                                w_last;
  sdd_wf_beat_t                        w_beat;
  logic [STALL_CNT_W-1:0]              r_lanes_stall;
  logic [NUM_REQ-1:0][STALL_CNT_W-1:0] r_starve;

  cr_xp10_decomp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_valid  (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // r_lock_id tracks the last selection, so it serves as lock target, pending target and idle grant.
  assign w_hold  = (r_state == ARB_LOCKED) | r_pend | ~w_pick_any;
  assign w_sel   = w_hold ? r_lock_id : w_pick_idx;
  assign w_beat  = req_beat[w_sel];
  assign w_valid = req_valid[w_sel] & ~rst;
  assign w_xfer  = w_valid & lanes_wf_ready;
  assign w_last  = beat_is_last(w_beat);

  always_comb begin
    req_ready = '0;
    if (!rst) req_ready[w_sel] = lanes_wf_ready;
  end

  assign wf_lanes_valid  = w_valid;
  assign wf_lanes_beat   = rst ? '0 : w_beat;
  assign grant_id        = rst ? '0 : w_sel;
  assign grant_locked    = (r_state == ARB_LOCKED);
  assign sob_err_stb     = r_sob_err;
  assign lanes_stall_cnt = r_lanes_stall;
  assign starve_cnt      = r_starve;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_pend    <= 1'b0;
      r_sob_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_pend    <= w_pend_nxt;
      r_sob_err <= w_sob_err_nxt;
    end
  end

  // Lock FSM: a non-final beat locks onto its source; a final beat releases and advances rr_ptr.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = w_sel;
    w_pend_nxt    = 1'b0;
    w_sob_err_nxt = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_pend_nxt = w_valid & ~lanes_wf_ready;
        if (w_xfer) begin
          w_sob_err_nxt = ~w_beat.sob;
          if (!w_last) w_state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (w_xfer && w_last) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
    if (w_xfer && w_last) begin
      w_rr_ptr_nxt = (w_sel == LAST_IDX) ? '0 : IDX_W'(w_sel + 1'b1);
    end
  end

  // Saturating monitors; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lanes_stall <= '0;
      r_starve      <= '0;
    end else begin
      if (stall_cnt_clr) begin
        r_lanes_stall <= '0;
      end else if (w_valid && !lanes_wf_ready && (r_lanes_stall != CNT_MAX)) begin
        r_lanes_stall <= r_lanes_stall + STALL_CNT_W'(1);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stall_cnt_clr || (w_xfer && (w_sel == IDX_W'(i)))) begin
          r_starve[i] <= '0;
        end else if (req_valid[i] && (w_sel != IDX_W'(i)) && (r_starve[i] != CNT_MAX)) begin
          r_starve[i] <= r_starve[i] + STALL_CNT_W'(1);
        end
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_pick_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(w_pick_onehot));
  a_lock_exclusive: assert property (@(posedge clk) disable iff (rst)
    (r_state == ARB_LOCKED) |-> ((req_ready & ~(NUM_REQ'(1) << r_lock_id)) == '0));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (wf_lanes_valid && !lanes_wf_ready) |=> (wf_lanes_valid && $stable(wf_lanes_beat)));

endmodule

// File: tb/tb_cr_xp10_decomp_sdd_wf_arb.sv
// Directed bench for the SDD word-fetch arbiter: two requesters, default and 4-bit counter instances.
module tb_cr_xp10_decomp_sdd_wf_arb;
  import cr_xp10_decomp_sdd_wf_arb_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              req_valid;
  sdd_wf_beat_t [1:0]      req_beat;
  logic                    lanes_wf_ready;
  logic                    stall_cnt_clr;
  logic [1:0]              req_ready;
  logic                    wf_lanes_valid;
  sdd_wf_beat_t            wf_lanes_beat;
  logic [0:0]              grant_id;
  logic                    grant_locked;
  logic                    sob_err_stb;
  logic [15:0]             lanes_stall_cnt;
  logic [1:0][15:0]        starve_cnt;
  logic [1:0]              d4_req_ready;
  logic                    d4_valid;
  sdd_wf_beat_t            d4_beat;
  logic [0:0]              d4_grant_id;
  logic                    d4_locked;
  logic                    d4_sob_err;
  logic [3:0]              d4_stall_cnt;
  logic [1:0][3:0]         d4_starve;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cr_xp10_decomp_sdd_wf_arb #(.NUM_REQ(2), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_beat(req_beat), .req_ready(req_ready),
    .wf_lanes_valid(wf_lanes_valid), .wf_lanes_beat(wf_lanes_beat), .lanes_wf_ready(lanes_wf_ready),
    .grant_id(grant_id), .grant_locked(grant_locked), .sob_err_stb(sob_err_stb),
    .stall_cnt_clr(stall_cnt_clr), .lanes_stall_cnt(lanes_stall_cnt), .starve_cnt(starve_cnt)
  );

  cr_xp10_decomp_sdd_wf_arb #(.NUM_REQ(2), .STALL_CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_beat(req_beat), .req_ready(d4_req_ready),
    .wf_lanes_valid(d4_valid), .wf_lanes_beat(d4_beat), .lanes_wf_ready(lanes_wf_ready),
    .grant_id(d4_grant_id), .grant_locked(d4_locked), .sob_err_stb(d4_sob_err),
    .stall_cnt_clr(stall_cnt_clr), .lanes_stall_cnt(d4_stall_cnt), .starve_cnt(d4_starve)
  );

  function automatic sdd_wf_beat_t mk(input logic [7:0] tag, input logic sob, input logic eob,
                                      input logic eof);
    sdd_wf_beat_t b;
    b                = '0;
    b.data           = {16{tag}};
    b.numbits        = 8'h80;
    b.sob            = sob;
    b.eob            = eob;
    b.eof            = eof;
    b.frame_bytes_in = 28'(tag);
    return b;
  endfunction

  // Inputs change just after the falling edge; outputs are examined 1 time unit later.
  task automatic drive(input logic [1:0] v, input sdd_wf_beat_t b0, input sdd_wf_beat_t b1,
                       input logic rdy, input logic clr);
    @(negedge clk);
    req_valid      = v;
    req_beat[0]    = b0;
    req_beat[1]    = b1;
    lanes_wf_ready = rdy;
    stall_cnt_clr  = clr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_beat = '0; lanes_wf_ready = 1'b0; stall_cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_beat = '0; lanes_wf_ready = 1'b0; stall_cnt_clr = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (wf_lanes_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", wf_lanes_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    n_checks++; if (grant_locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got=%0b exp=0", grant_locked); end
    n_checks++; if (sob_err_stb !== 1'b0) begin n_fail++; $display("FAIL rst_soberr got=%0b exp=0", sob_err_stb); end
    n_checks++; if (lanes_stall_cnt !== 16'd0 || starve_cnt !== '0) begin n_fail++; $display("FAIL rst_cnts got=%0d/%h exp=0", lanes_stall_cnt, starve_cnt); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Three-beat block from req0 only, then both present single-beat blocks.
  task automatic test_single_source();
    drive(2'b01, mk(8'h10, 1, 0, 0), '0, 1, 0);
    n_checks++; if (wf_lanes_valid !== 1'b1 || grant_id !== 1'b0) begin n_fail++; $display("FAIL t1_b0 valid=%0b grant=%0d exp 1/0", wf_lanes_valid, grant_id); end
    n_checks++; if (req_ready !== 2'b01 || grant_locked !== 1'b0) begin n_fail++; $display("FAIL t1_b0_rdy ready=%b locked=%0b exp 01/0", req_ready, grant_locked); end
    n_checks++; if (wf_lanes_beat !== mk(8'h10, 1, 0, 0)) begin n_fail++; $display("FAIL t1_b0_beat got=%h", wf_lanes_beat); end
    drive(2'b01, mk(8'h11, 0, 0, 0), '0, 1, 0);
    n_checks++; if (grant_locked !== 1'b1 || grant_id !== 1'b0) begin n_fail++; $display("FAIL t1_b1 locked=%0b grant=%0d exp 1/0", grant_locked, grant_id); end
    drive(2'b01, mk(8'h12, 0, 1, 0), '0, 1, 0);
    n_checks++; if (grant_locked !== 1'b1 || wf_lanes_valid !== 1'b1) begin n_fail++; $display("FAIL t1_b2 locked=%0b valid=%0b exp 1/1", grant_locked, wf_lanes_valid); end
    n_checks++; if (sob_err_stb !== 1'b0) begin n_fail++; $display("FAIL t1_no_soberr got=%0b exp=0", sob_err_stb); end
    drive(2'b11, mk(8'h13, 1, 1, 0), mk(8'h14, 1, 1, 0), 1, 0);
    n_checks++; if (grant_locked !== 1'b0 || grant_id !== 1'b1) begin n_fail++; $display("FAIL t1_rrptr locked=%0b grant=%0d exp 0/1", grant_locked, grant_id); end
    n_checks++; if (req_ready !== 2'b10 || wf_lanes_beat.data[7:0] !== 8'h14) begin n_fail++; $display("FAIL t1_r1 ready=%b tag=%h exp 10/14", req_ready, wf_lanes_beat.data[7:0]); end
    drive(2'b00, '0, '0, 1, 0);
    n_checks++; if (grant_locked !== 1'b0 || wf_lanes_valid !== 1'b0) begin n_fail++; $display("FAIL t1_single locked=%0b valid=%0b exp 0/0", grant_locked, wf_lanes_valid); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL t1_hold_grant got=%0d exp=1", grant_id); end
  endtask

  // Both sources send 2-beat blocks from reset: order r0,r0,r1,r1,r0,r0.
  task automatic test_round_robin();
    logic [7:0] t0 [6] = '{8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h23};
    logic       e0 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t1 [6] = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h32, 8'h32};
    logic       e1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [0:0] eg [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       el [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] et [6] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h22, 8'h23};
    int         s0 [6] = '{0, 0, 0, 1, 2, 0};
    int         s1 [6] = '{0, 1, 2, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(2'b11, mk(t0[c], ~e0[c], e0[c], 0), mk(t1[c], ~e1[c], e1[c], 0), 1, 0);
      n_checks++; if (grant_id !== eg[c] || grant_locked !== el[c]) begin n_fail++; $display("FAIL t2_order c=%0d grant=%0d locked=%0b exp %0d/%0b", c, grant_id, grant_locked, eg[c], el[c]); end
      n_checks++; if (wf_lanes_beat.data[7:0] !== et[c]) begin n_fail++; $display("FAIL t2_data c=%0d got=%h exp=%h", c, wf_lanes_beat.data[7:0], et[c]); end
      n_checks++; if (starve_cnt[0] !== 16'(s0[c]) || starve_cnt[1] !== 16'(s1[c])) begin n_fail++; $display("FAIL t2_starve c=%0d got=%0d/%0d exp %0d/%0d", c, starve_cnt[0], starve_cnt[1], s0[c], s1[c]); end
    end
    drive(2'b00, '0, '0, 1, 0);
  endtask

  // req1 bubbles mid-block for 4 cycles; req0 waits, no re-arbitration.
  task automatic test_lock_bubble();
    drive(2'b11, mk(8'h40, 1, 0, 0), mk(8'h50, 1, 0, 0), 1, 0);
    n_checks++; if (grant_id !== 1'b1 || wf_lanes_beat.data[7:0] !== 8'h50) begin n_fail++; $display("FAIL t3_start grant=%0d tag=%h exp 1/50", grant_id, wf_lanes_beat.data[7:0]); end
    for (int c = 0; c < 4; c++) begin
      drive(2'b01, mk(8'h40, 1, 0, 0), '0, 1, 0);
      n_checks++; if (wf_lanes_valid !== 1'b0 || req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL t3_bubble c=%0d valid=%0b ready0=%0b exp 0/0", c, wf_lanes_valid, req_ready[0]); end
      n_checks++; if (grant_id !== 1'b1 || grant_locked !== 1'b1) begin n_fail++; $display("FAIL t3_lock c=%0d grant=%0d locked=%0b exp 1/1", c, grant_id, grant_locked); end
    end
    drive(2'b11, mk(8'h40, 1, 0, 0), mk(8'h51, 0, 1, 0), 1, 0);
    n_checks++; if (wf_lanes_valid !== 1'b1 || wf_lanes_beat.data[7:0] !== 8'h51) begin n_fail++; $display("FAIL t3_resume valid=%0b tag=%h exp 1/51", wf_lanes_valid, wf_lanes_beat.data[7:0]); end
    drive(2'b01, mk(8'h41, 1, 1, 0), '0, 1, 0);
    n_checks++; if (grant_id !== 1'b0 || wf_lanes_valid !== 1'b1 || grant_locked !== 1'b0) begin n_fail++; $display("FAIL t3_r0 grant=%0d valid=%0b locked=%0b exp 0/1/0", grant_id, wf_lanes_valid, grant_locked); end
    n_checks++; if (starve_cnt[0] !== 16'd6) begin n_fail++; $display("FAIL t3_starve0 got=%0d exp=6", starve_cnt[0]); end
  endtask

  // Downstream back-pressure: stall counting, saturation, pending hold, clear priority.
  task automatic test_stall();
    sdd_wf_beat_t x;
    x = mk(8'h60, 1, 1, 0);
    for (int k = 0; k < 21; k++) begin
      drive((k >= 3) ? 2'b11 : 2'b01, x, mk(8'h61, 1, 1, 0), 0, 0);
      n_checks++; if (wf_lanes_valid !== 1'b1 || wf_lanes_beat !== x || grant_id !== 1'b0) begin n_fail++; $display("FAIL t4_hold k=%0d valid=%0b grant=%0d tag=%h", k, wf_lanes_valid, grant_id, wf_lanes_beat.data[7:0]); end
      if (k == 10 || k == 16 || k == 20) begin
        n_checks++; if (lanes_stall_cnt !== 16'(k)) begin n_fail++; $display("FAIL t4_cnt k=%0d got=%0d exp=%0d", k, lanes_stall_cnt, k); end
        n_checks++; if (d4_stall_cnt !== ((k > 15) ? 4'd15 : 4'(k))) begin n_fail++; $display("FAIL t4_sat k=%0d got=%0d", k, d4_stall_cnt); end
      end
    end
    drive(2'b11, x, mk(8'h61, 1, 1, 0), 0, 1);
    drive(2'b11, x, mk(8'h61, 1, 1, 0), 1, 0);
    n_checks++; if (lanes_stall_cnt !== 16'd0 || d4_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL t4_clr got=%0d/%0d exp 0/0", lanes_stall_cnt, d4_stall_cnt); end
    n_checks++; if (starve_cnt[1] !== 16'd0) begin n_fail++; $display("FAIL t4_clr_starve got=%0d exp=0", starve_cnt[1]); end
    n_checks++; if (req_ready !== 2'b01 || grant_id !== 1'b0) begin n_fail++; $display("FAIL t4_xfer ready=%b grant=%0d exp 01/0", req_ready, grant_id); end
    drive(2'b10, '0, mk(8'h61, 1, 1, 0), 1, 0);
    n_checks++; if (grant_id !== 1'b1 || wf_lanes_beat.data[7:0] !== 8'h61) begin n_fail++; $display("FAIL t4_next grant=%0d tag=%h exp 1/61", grant_id, wf_lanes_beat.data[7:0]); end
  endtask

  // First beat without sob is forwarded unchanged and flagged once.
  task automatic test_sob_err();
    sdd_wf_beat_t z;
    z = mk(8'h70, 0, 1, 0);
    z.numbits = 8'h40;
    drive(2'b01, z, '0, 1, 0);
    n_checks++; if (wf_lanes_beat !== z || wf_lanes_valid !== 1'b1) begin n_fail++; $display("FAIL t5_fwd valid=%0b beat=%h", wf_lanes_valid, wf_lanes_beat); end
    n_checks++; if (sob_err_stb !== 1'b0) begin n_fail++; $display("FAIL t5_pre got=%0b exp=0", sob_err_stb); end
    drive(2'b00, '0, '0, 1, 0);
    n_checks++; if (sob_err_stb !== 1'b1) begin n_fail++; $display("FAIL t5_pulse got=%0b exp=1", sob_err_stb); end
    drive(2'b00, '0, '0, 1, 0);
    n_checks++; if (sob_err_stb !== 1'b0) begin n_fail++; $display("FAIL t5_once got=%0b exp=0", sob_err_stb); end
  endtask

  // Reset mid-block drops the lock; afterwards req1 wins from rr_ptr=0.
  task automatic test_reset_mid_block();
    drive(2'b01, mk(8'h80, 1, 0, 0), '0, 1, 0);
    drive(2'b01, mk(8'h81, 0, 0, 0), '0, 1, 0);
    n_checks++; if (grant_locked !== 1'b1 || grant_id !== 1'b0) begin n_fail++; $display("FAIL t6_pre locked=%0b grant=%0d exp 1/0", grant_locked, grant_id); end
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; req_beat[1] = mk(8'h90, 1, 0, 0);
    #1;
    n_checks++; if (wf_lanes_valid !== 1'b0 || req_ready !== 2'b00 || grant_locked !== 1'b0) begin n_fail++; $display("FAIL t6_rst valid=%0b ready=%b locked=%0b exp 0", wf_lanes_valid, req_ready, grant_locked); end
    n_checks++; if (wf_lanes_beat !== '0 || grant_id !== 1'b0 || sob_err_stb !== 1'b0) begin n_fail++; $display("FAIL t6_rst_out grant=%0d soberr=%0b beat=%h exp 0", grant_id, sob_err_stb, wf_lanes_beat); end
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b10; req_beat[0] = '0;
    #1;
    n_checks++; if (grant_id !== 1'b1 || wf_lanes_valid !== 1'b1 || req_ready !== 2'b10) begin n_fail++; $display("FAIL t6_post grant=%0d valid=%0b ready=%b exp 1/1/10", grant_id, wf_lanes_valid, req_ready); end
    n_checks++; if (grant_locked !== 1'b0 || wf_lanes_beat.data[7:0] !== 8'h90) begin n_fail++; $display("FAIL t6_nolock locked=%0b tag=%h exp 0/90", grant_locked, wf_lanes_beat.data[7:0]); end
    drive(2'b00, '0, '0, 1, 0);
    n_checks++; if (grant_locked !== 1'b1 || grant_id !== 1'b1) begin n_fail++; $display("FAIL t6_relock locked=%0b grant=%0d exp 1/1", grant_locked, grant_id); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_lock_bubble();
    test_stall();
    test_sob_err();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
